// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM state encoding and iteration count for the execute-stage mul/div unit.
package muldiv_pkg;

  localparam int ITER_DEFAULT = 32;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Magnitude of a 32-bit value; 80000000 maps to itself, which the overflow case relies on.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder and
// subtract the divisor when it fits, shifting the resulting quotient bit in.
module muldiv_div_step (
  input  logic [31:0] i_rem,
  input  logic [31:0] i_quo,
  input  logic [31:0] i_div,
  output logic [31:0] o_rem,
  output logic [31:0] o_quo
);

  logic [32:0] w_shift;
  logic [31:0] w_diff;
  logic        w_ge;

  assign w_shift = {i_rem, i_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, i_div});
  // When the subtraction is taken the true difference is below the divisor, so 32 bits suffice.
  assign w_diff  = w_shift[31:0] - i_div;
  assign o_rem   = w_ge ? w_diff : w_shift[31:0];
  assign o_quo   = {i_quo[30:0], w_ge};

endmodule

// File: rtl/pipeline_execute_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers for the execute stage.
// Define PIPELINE_EXECUTE_MULDIV_FAST_MUL_EN to replace the shift-add multiply with a single-cycle multiplier.
module pipeline_execute_muldiv
  import muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        StartE,
  input  logic [2:0]  MulDivOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        ReadHiLoE,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        Busy,
  output logic        StallReq,
  output logic        Done
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t           r_state;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_a;
  logic [31:0]      r_b;
  logic [63:0]      r_acc;
  logic             r_is_div;
  logic             r_dz;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_signed;
  logic [31:0]      w_a_mag;
  logic [31:0]      w_b_mag;
  logic [31:0]      w_step_rem;
  logic [31:0]      w_step_quo;
  logic [63:0]      w_prod;
  logic [31:0]      w_fix_hi;
  logic [31:0]      w_fix_lo;

  assign w_signed = (MulDivOpE == OP_MULT) || (MulDivOpE == OP_DIV);
  assign w_a_mag  = mag32(SrcAE, w_signed);
  assign w_b_mag  = mag32(SrcBE, w_signed);

  // Divide datapath: r_acc holds {remainder, quotient/dividend}.
  muldiv_div_step u_div_step (
    .i_rem (r_acc[63:32]),
    .i_quo (r_acc[31:0]),
    .i_div (r_b),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  always_comb begin
    w_prod   = r_neg_q ? (~r_acc + 64'd1) : r_acc;
    w_fix_hi = w_prod[63:32];
    w_fix_lo = w_prod[31:0];
    if (r_dz) begin
      w_fix_hi = r_acc[63:32];
      w_fix_lo = r_acc[31:0];
    end else if (r_is_div) begin
      w_fix_lo = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
      w_fix_hi = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (StartE) begin
            case (MulDivOpE)
              OP_MULT, OP_MULTU: begin
                r_is_div <= 1'b0;
                r_dz     <= 1'b0;
                r_neg_q  <= w_signed && (SrcAE[31] ^ SrcBE[31]);
                r_neg_r  <= 1'b0;
                r_cnt    <= '0;
`ifdef PIPELINE_EXECUTE_MULDIV_FAST_MUL_EN
                r_acc    <= {32'd0, w_a_mag} * {32'd0, w_b_mag};
                r_state  <= FIX;
`else
                r_a      <= {32'd0, w_a_mag};
                r_b      <= w_b_mag;
                r_acc    <= '0;
                r_state  <= MUL;
`endif
              end
              OP_DIV, OP_DIVU: begin
                r_is_div <= 1'b1;
                r_cnt    <= '0;
                r_b      <= w_b_mag;
                r_neg_q  <= w_signed && (SrcAE[31] ^ SrcBE[31]);
                r_neg_r  <= w_signed && SrcAE[31];
                // Divide by zero skips the iterations and writes the fixed result pattern.
                if (SrcBE == 32'd0) begin
                  r_dz    <= 1'b1;
                  r_acc   <= {SrcAE, 32'hFFFF_FFFF};
                  r_state <= FIX;
                end else begin
                  r_dz    <= 1'b0;
                  r_acc   <= {32'd0, w_a_mag};
                  r_state <= DIV;
                end
              end
              OP_MTHI: r_hi <= SrcAE;
              OP_MTLO: r_lo <= SrcAE;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (r_b[0]) begin
            r_acc <= r_acc + r_a;
          end
          r_a <= r_a << 1;
          r_b <= r_b >> 1;
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DIV: begin
          r_acc <= {w_step_rem, w_step_quo};
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign HiOut    = r_hi;
  assign LoOut    = r_lo;
  assign Busy     = (r_state != IDLE);
  assign StallReq = Busy && (StartE || ReadHiLoE);
  assign Done     = r_done;

endmodule
